seq101_frame_tx: RTL and testbench

- Serial frame transmitter that emits the "101" sync preamble and then a parallel payload word, MSB first, one bit per clock.
- It is the transmit end of the team's 101-sync serial link. Its output feeds the 101 sequence detectors and acts as their stimulus source.
- A trailing gap of zeros guarantees that any non-overlapping 101 detector downstream returns to its idle state between frames.

---
 rtl/seq101_pkg.sv | 23 ++
 rtl/seq101_piso.sv | 28 ++
 rtl/seq101_frame_tx.sv | 136 +++++++++++++
 tb/tb_seq101_frame_tx.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/seq101_pkg.sv
// Shared types and constants for the 101-sync serial link transmitter.
// Holds the FSM state encoding, the sync preamble and a frame-length helper.
package seq101_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE_A,
    PRE_B,
    PRE_C,
    DATA,
    PAR,
    GAP
  } state_t;

  localparam logic [2:0] SYNC_PATTERN = 3'b101;
  localparam int         SYNC_LEN     = 3;

  // Cycles from the first preamble bit to the last gap bit, inclusive.
  function automatic int frame_len(input int data_w, input int gap_len, input bit parity_en);
    return SYNC_LEN + data_w + (parity_en ? 1 : 0) + gap_len;
  endfunction

endpackage

// File: rtl/seq101_piso.sv
// Parallel-in/serial-out shift register, MSB first; load has priority over shift.
// One-cycle latency from load to MSB visible; no flow control of its own.
module seq101_piso #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              msb
);

  logic [DATA_W-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= sr << 1;
    end
  end

  assign msb = sr[DATA_W-1];

endmodule

// File: rtl/seq101_frame_tx.sv
// 101-sync frame transmitter: preamble, DATA_W payload bits MSB first, GAP_LEN zeros; all outputs registered.
// Line follows accept by one cycle; in_ready only in IDLE, so one frame per L+1 cycles. SEQ101_TX_PARITY_EN adds an even-parity bit.
module seq101_frame_tx
  import seq101_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int GAP_LEN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              data_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int MAX_LEN = (DATA_W > GAP_LEN) ? DATA_W : GAP_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_LEN - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             shift;
  logic             msb;
  logic             data_out_d;
  logic             busy_d;
  logic             frame_done_d;

  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  // Shifting on entry to each DATA cycle keeps the MSB one bit ahead of the line flop.
  assign shift    = (state_d == DATA);

  seq101_piso #(
    .DATA_W(DATA_W)
  ) u_piso (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .shift(shift),
    .din  (in_data),
    .msb  (msb)
  );

`ifdef SEQ101_TX_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= ^in_data;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  if (accept) state_d = PRE_A;
      PRE_A: state_d = PRE_B;
      PRE_B: state_d = PRE_C;
      PRE_C: begin
        state_d = DATA;
        cnt_d   = DATA_LOAD;
      end
      DATA: begin
        if (cnt_q == '0) begin
`ifdef SEQ101_TX_PARITY_EN
          state_d = PAR;
`else
          state_d = GAP;
          cnt_d   = GAP_LOAD;
`endif
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
`ifdef SEQ101_TX_PARITY_EN
      PAR: begin
        state_d = GAP;
        cnt_d   = GAP_LOAD;
      end
`endif
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output flops are loaded with the bit belonging to the state being entered.
  always_comb begin
    data_out_d = 1'b0;
    case (state_d)
      PRE_A: data_out_d = SYNC_PATTERN[2];
      PRE_B: data_out_d = SYNC_PATTERN[1];
      PRE_C: data_out_d = SYNC_PATTERN[0];
      DATA:  data_out_d = msb;
`ifdef SEQ101_TX_PARITY_EN
      PAR:   data_out_d = par_q;
`endif
      default: data_out_d = 1'b0;
    endcase
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == GAP) && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_out   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out   <= data_out_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_seq101_frame_tx.sv
// Directed bench: an 8-bit/gap-2 transmitter plus a 1-bit/gap-1 instance on the same clock and reset.
module tb_seq101_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready, data_out, busy, frame_done;

  logic       in_valid1;
  logic [0:0] in_data1;
  logic       in_ready1, data_out1, busy1, frame_done1;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq101_frame_tx #(.DATA_W(8), .GAP_LEN(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .busy      (busy),
    .frame_done(frame_done)
  );

  seq101_frame_tx #(.DATA_W(1), .GAP_LEN(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_data   (in_data1),
    .in_ready  (in_ready1),
    .data_out  (data_out1),
    .busy      (busy1),
    .frame_done(frame_done1)
  );

  // Hand-computed line streams, first transmitted bit in the MSB position.
`ifdef SEQ101_TX_PARITY_EN
  localparam int          FL   = 14;
  localparam logic [15:0] E_A5 = 16'b10110100101000;
  localparam logic [15:0] E_3C = 16'b10100111100000;
  localparam logic [15:0] E_07 = 16'b10100000111100;
  localparam logic [15:0] E_00 = 16'b10100000000000;
  localparam int          P1   = 7;
  localparam logic [7:0]  E1   = 8'b1011100;
`else
  localparam int          FL   = 13;
  localparam logic [15:0] E_A5 = 16'b1011010010100;
  localparam logic [15:0] E_3C = 16'b1010011110000;
  localparam logic [15:0] E_07 = 16'b1010000011100;
  localparam logic [15:0] E_00 = 16'b1010000000000;
  localparam int          P1   = 6;
  localparam logic [7:0]  E1   = 8'b101100;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Call from an IDLE cycle (#1 after an edge); returns #1 into the following IDLE cycle.
  task automatic run_frame(input string tag, input logic [7:0] word, input logic [15:0] exp,
                           input bit keep, input logic [7:0] hold);
    in_valid = 1'b1;
    in_data  = word;
    for (int i = 1; i <= FL; i++) begin
      @(posedge clk); #1;
      if (keep) in_data = hold;
      else      in_valid = 1'b0;
      check($sformatf("%s c%0d data_out", tag, i), 32'(data_out), 32'(exp[FL-i]));
      check($sformatf("%s c%0d busy", tag, i), 32'(busy), 32'd1);
      check($sformatf("%s c%0d frame_done", tag, i), 32'(frame_done), 32'(i == FL));
      check($sformatf("%s c%0d in_ready", tag, i), 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    check($sformatf("%s idle busy", tag), 32'(busy), 32'd0);
    check($sformatf("%s idle frame_done", tag), 32'(frame_done), 32'd0);
    check($sformatf("%s idle data_out", tag), 32'(data_out), 32'd0);
    check($sformatf("%s idle in_ready", tag), 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [5:0] eff;
    int pos;
    eff       = 6'b101111;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_valid1 = 1'b0;
    in_data1  = 1'b0;

    // Reset state
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("rst%0d data_out", c), 32'(data_out), 32'd0);
      check($sformatf("rst%0d busy", c), 32'(busy), 32'd0);
      check($sformatf("rst%0d frame_done", c), 32'(frame_done), 32'd0);
      check($sformatf("rst%0d in_ready", c), 32'(in_ready), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst in_ready", 32'(in_ready), 32'd1);
    check("post_rst busy", 32'(busy), 32'd0);
    check("post_rst data_out", 32'(data_out), 32'd0);

    // Single frame
    run_frame("a5", 8'hA5, E_A5, 1'b0, 8'h00);

    // Held valid while busy: next word taken in the IDLE cycle
    run_frame("a5_hold", 8'hA5, E_A5, 1'b1, 8'h3C);
    run_frame("3c", 8'h3C, E_3C, 1'b0, 8'h00);
    run_frame("07", 8'h07, E_07, 1'b0, 8'h00);

    // Reset during payload bit 3 abandons the frame
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      check($sformatf("ff c%0d data_out", i), 32'(data_out), 32'(eff[6-i]));
      check($sformatf("ff c%0d busy", i), 32'(busy), 32'd1);
      check($sformatf("ff c%0d frame_done", i), 32'(frame_done), 32'd0);
    end
    rst = 1'b1;
    #1;
    check("midrst in_ready forced", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("midrst data_out", 32'(data_out), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("after_midrst in_ready", 32'(in_ready), 32'd1);
    check("after_midrst data_out", 32'(data_out), 32'd0);
    check("after_midrst frame_done", 32'(frame_done), 32'd0);
    run_frame("00", 8'h00, E_00, 1'b0, 8'h00);

    // Minimal configuration under continuous valid: two back-to-back frame periods
    in_valid1 = 1'b1;
    in_data1  = 1'b1;
    for (int i = 1; i <= 2 * P1; i++) begin
      @(posedge clk); #1;
      pos = (i - 1) % P1;
      check($sformatf("w1 c%0d data_out", i), 32'(data_out1), 32'(E1[P1-1-pos]));
      check($sformatf("w1 c%0d frame_done", i), 32'(frame_done1), 32'(pos == P1 - 2));
      check($sformatf("w1 c%0d busy", i), 32'(busy1), 32'(pos != P1 - 1));
      check($sformatf("w1 c%0d in_ready", i), 32'(in_ready1), 32'(pos == P1 - 1));
    end
    in_valid1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
